// File: rtl/mmio_arbiter_if.sv
// AXI-Lite master port bundle shared by the MMIO arbiter and its slave.
interface mmio_arbiter_if;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arvalid, rready,
        output awready, wready, bresp, bvalid,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/mmio_arbiter.sv
// Round-robin two-port MMIO arbiter driving one AXI-Lite master port,
// with a per-transaction watchdog that aborts hung slave handshakes.
module mmio_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_valid_i,
    input  logic        req0_we_i,
    input  logic [31:0] req0_addr_i,
    input  logic [31:0] req0_wdata_i,
    input  logic [3:0]  req0_wstrb_i,
    output logic        done0_o,
    output logic [31:0] req0_rdata_o,
    output logic        req0_err_o,
    input  logic        req1_valid_i,
    input  logic        req1_we_i,
    input  logic [31:0] req1_addr_i,
    input  logic [31:0] req1_wdata_i,
    input  logic [3:0]  req1_wstrb_i,
    output logic        done1_o,
    output logic [31:0] req1_rdata_o,
    output logic        req1_err_o,
    mmio_arbiter_if.master m_axi
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WRITE = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [2:0]  r_state;
    logic        r_last_grant;
    logic        r_gnt;
    logic        r_we;
    logic [15:0] r_wdog;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic        r_awvalid;
    logic        r_wvalid;
    logic        r_arvalid;
    logic        r_done0;
    logic        r_done1;
    logic [31:0] r_rdata0;
    logic [31:0] r_rdata1;
    logic        r_err0;
    logic        r_err1;

    logic        w_busy;
    logic        w_any;
    logic        w_pick1;
    logic        w_tmo;
    logic        w_fin;
    logic        w_fin_err;
    logic        w_fin_ld;
    logic [31:0] w_fin_rdata;
    logic        w_aw_left;
    logic        w_w_left;

    assign m_axi.awaddr  = r_addr;
    assign m_axi.araddr  = r_addr;
    assign m_axi.wdata   = r_wdata;
    assign m_axi.wstrb   = r_wstrb;
    assign m_axi.awvalid = r_awvalid;
    assign m_axi.wvalid  = r_wvalid;
    assign m_axi.arvalid = r_arvalid;
    assign m_axi.bready  = (r_state == S_WRESP);
    assign m_axi.rready  = (r_state == S_RDATA);

    assign done0_o      = r_done0;
    assign done1_o      = r_done1;
    assign req0_rdata_o = r_rdata0;
    assign req1_rdata_o = r_rdata1;
    assign req0_err_o   = r_err0;
    assign req1_err_o   = r_err1;

    assign w_aw_left = r_awvalid & ~m_axi.awready;
    assign w_w_left  = r_wvalid & ~m_axi.wready;

    always_comb begin
        w_busy      = (r_state == S_WRITE) || (r_state == S_WRESP) ||
                      (r_state == S_RADDR) || (r_state == S_RDATA);
        w_any       = req0_valid_i | req1_valid_i;
        w_pick1     = req1_valid_i & (~req0_valid_i | ~r_last_grant);
        w_tmo       = w_busy && (r_wdog == TMO_LAST);
        w_fin       = 1'b0;
        w_fin_err   = 1'b0;
        w_fin_ld    = 1'b0;
        w_fin_rdata = 32'h0;
        // An abort wins over a handshake landing in the same cycle.
        if (w_tmo) begin
            w_fin     = 1'b1;
            w_fin_err = 1'b1;
            w_fin_ld  = ~r_we;
        end else if ((r_state == S_WRESP) && m_axi.bvalid) begin
            w_fin     = 1'b1;
            w_fin_err = (m_axi.bresp != 2'b00);
        end else if ((r_state == S_RDATA) && m_axi.rvalid) begin
            w_fin       = 1'b1;
            w_fin_err   = (m_axi.rresp != 2'b00);
            w_fin_ld    = 1'b1;
            w_fin_rdata = m_axi.rdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_we         <= 1'b0;
            r_wdog       <= 16'h0;
            r_addr       <= 32'h0;
            r_wdata      <= 32'h0;
            r_wstrb      <= 4'h0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_arvalid    <= 1'b0;
            r_done0      <= 1'b0;
            r_done1      <= 1'b0;
            r_rdata0     <= 32'h0;
            r_rdata1     <= 32'h0;
            r_err0       <= 1'b0;
            r_err1       <= 1'b0;
        end else begin
            r_done0 <= 1'b0;
            r_done1 <= 1'b0;
            if (w_busy) r_wdog <= r_wdog + 16'd1;
            if (w_fin) begin
                r_state   <= S_DONE;
                r_awvalid <= 1'b0;
                r_wvalid  <= 1'b0;
                r_arvalid <= 1'b0;
                if (r_gnt) begin
                    r_done1 <= 1'b1;
                    r_err1  <= w_fin_err;
                    if (w_fin_ld) r_rdata1 <= w_fin_rdata;
                end else begin
                    r_done0 <= 1'b1;
                    r_err0  <= w_fin_err;
                    if (w_fin_ld) r_rdata0 <= w_fin_rdata;
                end
            end else begin
                case (r_state)
                    S_IDLE: if (w_any) begin
                        r_gnt        <= w_pick1;
                        r_last_grant <= w_pick1;
                        r_wdog       <= 16'h0;
                        r_we    <= w_pick1 ? req1_we_i    : req0_we_i;
                        r_addr  <= w_pick1 ? req1_addr_i  : req0_addr_i;
                        r_wdata <= w_pick1 ? req1_wdata_i : req0_wdata_i;
                        r_wstrb <= w_pick1 ? req1_wstrb_i : req0_wstrb_i;
                        if (w_pick1 ? req1_we_i : req0_we_i) begin
                            r_state   <= S_WRITE;
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                        end else begin
                            r_state   <= S_RADDR;
                            r_arvalid <= 1'b1;
                        end
                    end
                    S_WRITE: begin
                        r_awvalid <= w_aw_left;
                        r_wvalid  <= w_w_left;
                        if (!w_aw_left && !w_w_left) r_state <= S_WRESP;
                    end
                    S_RADDR: if (m_axi.arready) begin
                        r_arvalid <= 1'b0;
                        r_state   <= S_RDATA;
                    end
                    S_WRESP, S_RDATA: r_state <= r_state;
                    S_DONE:  r_state <= S_IDLE;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mmio_arbiter.sv
// Directed bench for mmio_arbiter with a delay-programmable AXI-Lite slave.
module tb_mmio_arbiter;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    int n_req0 = 0, n_req1 = 0, n_done0 = 0, n_done1 = 0;
    logic        req0_we = 1'b0, req1_we = 1'b0;
    logic [31:0] req0_addr = '0, req1_addr = '0;
    logic [31:0] req0_wdata = '0, req1_wdata = '0;
    logic [3:0]  req0_wstrb = '0, req1_wstrb = '0;
    logic        req0_valid, req1_valid;
    logic        done0, done1, err0, err1;
    logic [31:0] rdata0, rdata1;

    assign req0_valid = (n_req0 != n_done0);
    assign req1_valid = (n_req1 != n_done1);

    mmio_arbiter_if axi ();

    mmio_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .req0_valid_i(req0_valid), .req0_we_i(req0_we),
        .req0_addr_i(req0_addr), .req0_wdata_i(req0_wdata),
        .req0_wstrb_i(req0_wstrb), .done0_o(done0),
        .req0_rdata_o(rdata0), .req0_err_o(err0),
        .req1_valid_i(req1_valid), .req1_we_i(req1_we),
        .req1_addr_i(req1_addr), .req1_wdata_i(req1_wdata),
        .req1_wstrb_i(req1_wstrb), .done1_o(done1),
        .req1_rdata_o(rdata1), .req1_err_o(err1),
        .m_axi(axi)
    );

    // Slave: each ready/valid appears after the programmed number of wait cycles.
    int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    int cnt_aw = 0, cnt_w = 0, cnt_b = 0, cnt_ar = 0, cnt_r = 0;

    assign axi.awready = axi.awvalid && (cnt_aw >= aw_dly);
    assign axi.wready  = axi.wvalid && (cnt_w >= w_dly);
    assign axi.bvalid  = axi.bready && (cnt_b >= b_dly);
    assign axi.bresp   = bresp_cfg;
    assign axi.arready = axi.arvalid && (cnt_ar >= ar_dly);
    assign axi.rvalid  = axi.rready && (cnt_r >= r_dly);
    assign axi.rresp   = rresp_cfg;
    assign axi.rdata   = rdata_cfg;

    int cyc = 0, aw_hs = -1, w_hs = -1, n_brise = 0;
    int done0_cyc = -1, done1_cyc = -1;
    logic bready_q = 1'b0;
    int glog[$];
    int gcyc[$];

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        cnt_aw <= (axi.awvalid && !axi.awready) ? cnt_aw + 1 : 0;
        cnt_w  <= (axi.wvalid && !axi.wready) ? cnt_w + 1 : 0;
        cnt_b  <= (axi.bready && !axi.bvalid) ? cnt_b + 1 : 0;
        cnt_ar <= (axi.arvalid && !axi.arready) ? cnt_ar + 1 : 0;
        cnt_r  <= (axi.rready && !axi.rvalid) ? cnt_r + 1 : 0;
        if (axi.awvalid && axi.awready) aw_hs <= cyc;
        if (axi.wvalid && axi.wready) w_hs <= cyc;
        bready_q <= axi.bready;
        if (axi.bready && !bready_q) n_brise <= n_brise + 1;
        if (done0) begin
            n_done0 <= n_done0 + 1;
            done0_cyc <= cyc;
            glog.push_back(0);
            gcyc.push_back(cyc);
        end
        if (done1) begin
            n_done1 <= n_done1 + 1;
            done1_cyc <= cyc;
            glog.push_back(1);
            gcyc.push_back(cyc);
        end
    end

    task automatic issue(input int p, input logic we, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s, input int n);
        if (p == 0) begin
            req0_we = we; req0_addr = a; req0_wdata = d; req0_wstrb = s;
            n_req0 = n_req0 + n;
        end else begin
            req1_we = we; req1_addr = a; req1_wdata = d; req1_wstrb = s;
            n_req1 = n_req1 + n;
        end
    endtask

    task automatic wait_all(input int budget);
        int t = 0;
        while ((n_done0 != n_req0 || n_done1 != n_req1) && t < budget) begin
            @(negedge clk);
            t++;
        end
        tests_run++;
        if (n_done0 != n_req0 || n_done1 != n_req1) begin
            tests_failed++;
            $display("FAIL completion_timeout: done %0d/%0d, required %0d/%0d",
                     n_done0, n_done1, n_req0, n_req1);
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        tests_run++;
        if ({done0, done1, err0, err1} !== 4'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b want 0000", {done0, done1, err0, err1});
        end
        tests_run++;
        if ({rdata0, rdata1} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_rdata: got %h %h want 0", rdata0, rdata1);
        end
        tests_run++;
        if ({axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_axi_vr: got %b want 00000",
                     {axi.awvalid, axi.wvalid, axi.bready, axi.arvalid, axi.rready});
        end
        tests_run++;
        if ({axi.awaddr, axi.wdata, axi.wstrb} !== 68'h0) begin
            tests_failed++;
            $display("FAIL reset_axi_data: got %h %h %h want 0",
                     axi.awaddr, axi.wdata, axi.wstrb);
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_write;
        int k, d1;
        k = cyc; d1 = n_done1;
        issue(0, 1'b1, 32'h4000_0000, 32'hA5A5_0001, 4'hF, 1);
        wait_all(20);
        tests_run++;
        if (aw_hs !== k + 1 || w_hs !== k + 1) begin
            tests_failed++;
            $display("FAIL wr_hs_cycle: got aw %0d w %0d want %0d", aw_hs - k, w_hs - k, 1);
        end
        tests_run++;
        if (done0_cyc !== k + 3) begin
            tests_failed++;
            $display("FAIL wr_latency: got %0d want 3", done0_cyc - k);
        end
        tests_run++;
        if (err0 !== 1'b0 || n_done1 !== d1) begin
            tests_failed++;
            $display("FAIL wr_err_done1: got err %b done1 +%0d want 0 +0", err0, n_done1 - d1);
        end
        tests_run++;
        if (axi.awaddr !== 32'h4000_0000 || axi.wdata !== 32'hA5A5_0001 || axi.wstrb !== 4'hF) begin
            tests_failed++;
            $display("FAIL wr_bus_hold: got %h %h %h want 40000000 a5a50001 f",
                     axi.awaddr, axi.wdata, axi.wstrb);
        end
    endtask

    task automatic test_read_wait;
        int k;
        ar_dly = 2; r_dly = 3; rdata_cfg = 32'h1234_5678;
        k = cyc;
        issue(1, 1'b0, 32'h4000_0008, 32'h0, 4'h0, 1);
        wait_all(30);
        tests_run++;
        if (done1_cyc !== k + 8) begin
            tests_failed++;
            $display("FAIL rd_latency: got %0d want 8", done1_cyc - k);
        end
        tests_run++;
        if (rdata1 !== 32'h1234_5678 || rdata0 !== 32'h0) begin
            tests_failed++;
            $display("FAIL rd_data: got %h %h want 12345678 00000000", rdata1, rdata0);
        end
        tests_run++;
        if (axi.araddr !== 32'h4000_0008 || err1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL rd_addr_err: got %h %b want 40000008 0", axi.araddr, err1);
        end
        ar_dly = 0; r_dly = 0;
    endtask

    task automatic test_back_to_back;
        int k, g0, d0, d1;
        rdata_cfg = 32'h0BAD_0004;
        k = cyc; g0 = glog.size(); d0 = n_done0; d1 = n_done1;
        issue(0, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 4);
        issue(1, 1'b0, 32'h0000_0200, 32'h0, 4'h0, 4);
        wait_all(80);
        tests_run++;
        if (glog.size() - g0 != 8 || n_done0 - d0 != 4 || n_done1 - d1 != 4) begin
            tests_failed++;
            $display("FAIL b2b_counts: got %0d/%0d want 4/4", n_done0 - d0, n_done1 - d1);
        end else begin
            for (int i = 0; i < 8; i++) begin
                tests_run++;
                if (glog[g0 + i] != (i % 2)) begin
                    tests_failed++;
                    $display("FAIL b2b_order[%0d]: got %0d want %0d", i, glog[g0 + i], i % 2);
                end
            end
            tests_run++;
            if (gcyc[g0 + 7] != k + 31) begin
                tests_failed++;
                $display("FAIL b2b_throughput: got %0d want 31", gcyc[g0 + 7] - k);
            end
        end
    endtask

    task automatic test_w_before_aw;
        int k, br, d0;
        aw_dly = 2; w_dly = 0;
        k = cyc; br = n_brise; d0 = n_done0;
        issue(0, 1'b1, 32'h4000_0010, 32'h5555_AAAA, 4'h3, 1);
        while (cyc < k + 2) @(negedge clk);
        tests_run++;
        if (axi.wvalid !== 1'b0 || axi.awvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL split_valids: got w %b aw %b want 0 1", axi.wvalid, axi.awvalid);
        end
        wait_all(20);
        tests_run++;
        if (w_hs !== k + 1 || aw_hs !== k + 3) begin
            tests_failed++;
            $display("FAIL split_hs: got w %0d aw %0d want 1 3", w_hs - k, aw_hs - k);
        end
        tests_run++;
        if (n_brise - br != 1 || n_done0 - d0 != 1 || done0_cyc != k + 5) begin
            tests_failed++;
            $display("FAIL split_resp: got bphase %0d done %0d at %0d want 1 1 5",
                     n_brise - br, n_done0 - d0, done0_cyc - k);
        end
        aw_dly = 0;
    endtask

    task automatic test_err;
        bresp_cfg = 2'b10;
        issue(0, 1'b1, 32'h4000_0020, 32'h1, 4'hF, 1);
        wait_all(20);
        tests_run++;
        if (err0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL bresp_err: got %b want 1", err0);
        end
        bresp_cfg = 2'b00; rresp_cfg = 2'b00; rdata_cfg = 32'hCAFE_0001;
        issue(0, 1'b0, 32'h4000_0024, 32'h0, 4'h0, 1);
        wait_all(20);
        tests_run++;
        if (err0 !== 1'b0 || rdata0 !== 32'hCAFE_0001) begin
            tests_failed++;
            $display("FAIL err_clear: got %b %h want 0 cafe0001", err0, rdata0);
        end
        tests_run++;
        if (rdata1 !== 32'h0BAD_0004) begin
            tests_failed++;
            $display("FAIL rdata1_kept: got %h want 0bad0004", rdata1);
        end
    endtask

    task automatic test_timeout;
        int k;
        ar_dly = 1000;
        k = cyc;
        issue(0, 1'b0, 32'h4000_0030, 32'h0, 4'h0, 1);
        while (cyc < k + 8) @(negedge clk);
        tests_run++;
        if (axi.arvalid !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo_arvalid_hold: got %b want 1", axi.arvalid);
        end
        @(negedge clk);
        tests_run++;
        if (axi.arvalid !== 1'b0 || done0 !== 1'b1) begin
            tests_failed++;
            $display("FAIL tmo_abort: got arvalid %b done %b want 0 1", axi.arvalid, done0);
        end
        wait_all(20);
        tests_run++;
        if (err0 !== 1'b1 || rdata0 !== 32'h0 || done0_cyc != k + 9) begin
            tests_failed++;
            $display("FAIL tmo_status: got err %b rdata %h at %0d want 1 0 9",
                     err0, rdata0, done0_cyc - k);
        end
        ar_dly = 0;
    endtask

    task automatic test_reset_mid;
        int k, d0;
        r_dly = 10;
        k = cyc; d0 = n_done0;
        issue(0, 1'b0, 32'h4000_0040, 32'h0, 4'h0, 1);
        while (cyc < k + 2) @(negedge clk);
        tests_run++;
        if (axi.rready !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_in_rdata: got rready %b want 1", axi.rready);
        end
        rst_i = 1'b1;
        n_req0 = n_done0;
        @(negedge clk);
        tests_run++;
        if ({done0, done1, err0, err1, axi.rready, axi.arvalid} !== 6'b0 ||
            {rdata0, rdata1, axi.araddr} !== 96'h0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got %b %h %h %h want 0",
                     {done0, done1, err0, err1, axi.rready, axi.arvalid},
                     rdata0, rdata1, axi.araddr);
        end
        rst_i = 1'b0;
        r_dly = 0;
        repeat (4) @(negedge clk);
        tests_run++;
        if (n_done0 != d0) begin
            tests_failed++;
            $display("FAIL mid_no_done: got %0d pulses want 0", n_done0 - d0);
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_read_wait;
        test_back_to_back;
        test_w_before_aw;
        test_err;
        test_timeout;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
